muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations of the execute stage. The single-cycle ALU keeps the base-ISA operations.
- On START it latches the operands and the 5-bit ALU select code.
  - Multiply: one registered product cycle.
  - Divide/remainder: iterative 32-step restoring division.
- It stalls the pipeline via STALL until a one-cycle DONE pulse delivers RESULT.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
DIV_STEPS, 32, divide iterations; must equal XLEN

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset
START  input  1  request; accepted only when state is IDLE or DONE and SELECT[4:3]==2'b01
FLUSH  input  1  synchronous abort of the operation in flight
SELECT  input  5  ALU select code; SELECT[2:0] = funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
DATA1  input  32  rs1 operand (dividend / multiplicand)
DATA2  input  32  rs2 operand (divisor / multiplier)
RESULT  output  32  registered result; holds the last completed value
DONE  output  1  high for exactly the one cycle spent in DONE state
BUSY  output  1  state != IDLE
STALL  output  1  combinational pipeline hold request

Behaviour:
- Clock and reset: one clock CLK; RESET asynchronous, active-low.
- Reset (any time, including mid-operation):
  - state=IDLE; RESULT=0; DONE=0; BUSY=0.
  - Operand, quotient and remainder registers cleared.
- States: IDLE, MUL, DIV, DONE.
- Accept: START && SELECT[4:3]==01 && (state==IDLE || state==DONE) at edge N.
  - Latches DATA1, DATA2 and SELECT[2:0].
  - START with any other SELECT is ignored; no STALL is raised.
  - START in MUL/DIV is ignored; the upstream stage is already held.
- MUL path: edge N -> MUL.
  - Edge N+1: register the 64-bit product and go to DONE; DONE is high between edge N+1 and edge N+2.
  - Operand signedness: MUL signed x signed, low 32 bits. MULH signed x signed, high 32 bits. MULHSU DATA1 signed x DATA2 unsigned, high 32 bits. MULHU unsigned x unsigned, high 32 bits.
  - Sign extension is to 64 bits before the multiply.
- DIV path, special cases: detected at accept; go to DONE at edge N+1 without iterating.
  - Divisor==0: quotient=32'hFFFFFFFF; remainder=DATA1 (signed and unsigned forms).
  - Signed overflow (DATA1==32'h80000000, DATA2==32'hFFFFFFFF, DIV/REM): quotient=32'h80000000; remainder=0.
- DIV path, normal:
  - Operates on magnitudes (absolute values for DIV/REM, raw values for DIVU/REMU).
  - A 6-bit step counter is loaded with DIV_STEPS at accept. Each DIV cycle performs one shift-subtract step and decrements the counter.
  - The counter transitions to DONE at edge N+32; DONE is high between edge N+32 and edge N+33.
  - Sign fix, applied when RESULT is written: quotient negated if signs of DATA1 and DATA2 differ; remainder takes the sign of DATA1.
- RESULT is written only on entry to DONE and holds until the next completion.
- DONE exit:
  - DONE -> IDLE on the next edge.
  - Or DONE -> MUL/DIV if a new START is accepted in the same cycle (back-to-back, no idle gap).
- STALL = (START && M-op && state in {IDLE, DONE}) || state==MUL || state==DIV.
  - STALL is low in DONE unless a new op is starting, so the pipeline captures RESULT on that edge.
- FLUSH at an edge, state MUL or DIV:
  - Go to IDLE; no DONE; RESULT unchanged.
  - FLUSH has priority over completion and over START in the same cycle.
  - FLUSH in IDLE/DONE cancels any START presented that cycle.
- All arithmetic is 32-bit modular. The only >32-bit datapaths are the 64-bit product and the 33-bit partial-remainder subtract.

Test Plan:
- MUL, DATA1=7, DATA2=-3 -> DONE after edge N+1, RESULT=32'hFFFFFFEB; STALL high exactly 2 cycles (request cycle + MUL).
- MULH/MULHSU/MULHU with DATA1=32'h80000000, DATA2=32'hFFFFFFFF -> RESULT 32'h00000000 / 32'h80000000 / 32'h7FFFFFFF.
- DIV -7/2 -> RESULT=-3 (32'hFFFFFFFD); REM -7/2 -> RESULT=-1; DONE after edge N+32 exactly, BUSY high 33 cycles.
- DIVU 100/0 -> RESULT=32'hFFFFFFFF and REMU 100/0 -> RESULT=100, each after edge N+1; DIV 32'h80000000 / -1 -> RESULT=32'h80000000.
- Back-to-back: START DIVU 10/3 held through DONE of prior MUL -> no IDLE cycle, second DONE 32 cycles after first, RESULT=3.
- Abort: FLUSH at DIV step 10 -> IDLE next edge, no DONE, RESULT keeps old value; then RESET low mid-DIV -> RESULT=0, BUSY=0, DONE=0 immediately (asynchronous).

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the execute stage and the multi-cycle
// RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            START;
    logic            FLUSH;
    logic [4:0]      SELECT;
    logic [XLEN-1:0] DATA1;
    logic [XLEN-1:0] DATA2;
    logic [XLEN-1:0] RESULT;
    logic            DONE;
    logic            BUSY;
    logic            STALL;

    modport master (
        output START, FLUSH, SELECT, DATA1, DATA2,
        input  RESULT, DONE, BUSY, STALL
    );

    modport slave (
        input  START, FLUSH, SELECT, DATA1, DATA2,
        output RESULT, DONE, BUSY, STALL
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer: single registered multiply cycle or 32-step restoring
// divide, holding the pipeline through STALL until a one-cycle DONE.
module muldiv_sequencer #(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    muldiv_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic            special_q, special_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_mop;
    logic            can_accept;
    logic            accept;
    logic            sgn_div;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] d1_abs;
    logic [XLEN-1:0] d2_abs;

    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;
    logic [XLEN-1:0] div_res;
    logic [XLEN-1:0] spc_res;

    always_comb begin
        is_mop     = (bus.SELECT[4:3] == 2'b01);
        can_accept = (state_q == S_IDLE) || (state_q == S_DONE);
        accept     = bus.START && is_mop && can_accept && !bus.FLUSH;

        sgn_div = ~bus.SELECT[0];
        div0    = (bus.DATA2 == '0);
        ovf     = sgn_div
                  && (bus.DATA1 == {1'b1, {(XLEN-1){1'b0}}})
                  && (bus.DATA2 == '1);
        d1_abs  = (sgn_div && bus.DATA1[XLEN-1])
                  ? (~bus.DATA1 + 1'b1) : bus.DATA1;
        d2_abs  = (sgn_div && bus.DATA2[XLEN-1])
                  ? (~bus.DATA2 + 1'b1) : bus.DATA2;
    end

    // MULHU is the only unsigned rs1; only MUL/MULH treat rs2 as signed.
    always_comb begin
        a_ext = {{XLEN{(op_q != 3'b011) & a_q[XLEN-1]}}, a_q};
        b_ext = {{XLEN{~op_q[1] & b_q[XLEN-1]}}, b_q};
        prod  = a_ext * b_ext;
        if (op_q == 3'b000) begin
            mul_res = prod[XLEN-1:0];
        end else begin
            mul_res = prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        if (!diff[XLEN]) begin
            rem_step = diff[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step = shifted[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end
        q_fin   = qneg_q ? (~quo_step + 1'b1) : quo_step;
        r_fin   = rneg_q ? (~rem_step + 1'b1) : rem_step;
        div_res = op_q[1] ? r_fin : q_fin;
        spc_res = op_q[1] ? rem_q : quo_q;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        special_d = special_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d = bus.SELECT[2:0];
                    if (!bus.SELECT[2]) begin
                        state_d = S_MUL;
                        a_d     = bus.DATA1;
                        b_d     = bus.DATA2;
                    end else begin
                        state_d   = S_DIV;
                        cnt_d     = 6'(DIV_STEPS);
                        qneg_d    = sgn_div
                                    && (bus.DATA1[XLEN-1] ^ bus.DATA2[XLEN-1]);
                        rneg_d    = sgn_div && bus.DATA1[XLEN-1];
                        special_d = div0 || ovf;
                        b_d       = d2_abs;
                        unique case (1'b1)
                            div0: begin
                                quo_d = '1;
                                rem_d = bus.DATA1;
                            end
                            ovf: begin
                                quo_d = {1'b1, {(XLEN-1){1'b0}}};
                                rem_d = '0;
                            end
                            default: begin
                                quo_d = d1_abs;
                                rem_d = '0;
                            end
                        endcase
                    end
                end
            end
            S_MUL: begin
                if (bus.FLUSH) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = mul_res;
                end
            end
            S_DIV: begin
                if (bus.FLUSH) begin
                    state_d = S_IDLE;
                end else if (special_q) begin
                    state_d  = S_DONE;
                    result_d = spc_res;
                end else begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d  = S_DONE;
                        result_d = div_res;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            special_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            special_q <= special_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            result_q  <= result_d;
        end
    end

    assign bus.RESULT = result_q;
    assign bus.DONE   = (state_q == S_DONE);
    assign bus.BUSY   = (state_q != S_IDLE);
    assign bus.STALL  = (bus.START && is_mop && can_accept)
                        || (state_q == S_MUL) || (state_q == S_DIV);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer: latency, stall/busy shape,
// results, back-to-back issue, flush and asynchronous reset.
module tb_muldiv_sequencer;

    logic clk;
    logic rst_n;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .CLK  (clk),
        .RESET(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  sel;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [4:0] sel, input logic [31:0] d1,
                          input logic [31:0] d2, output logic [31:0] res,
                          output int lat, output int busy_n,
                          output int stall_n, output logic done_stall);
        bus.START  = 1'b1;
        bus.SELECT = sel;
        bus.DATA1  = d1;
        bus.DATA2  = d2;
        #1;
        stall_n = int'(bus.STALL);
        busy_n  = 0;
        @(posedge clk); #1;
        bus.START = 1'b0;
        lat = 0;
        while (!bus.DONE && lat < 40) begin
            busy_n  += int'(bus.BUSY);
            stall_n += int'(bus.STALL);
            @(posedge clk); #1;
            lat++;
        end
        res        = bus.RESULT;
        busy_n    += int'(bus.BUSY);
        done_stall = bus.STALL;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        int          lat;
        int          busy_n;
        int          stall_n;
        logic        dstall;
        logic        seen;

        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{"mul",      5'h08, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1};
        vecs[1]  = '{"mulh",     5'h09, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[2]  = '{"mulhsu",   5'h0A, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[3]  = '{"mulhu",    5'h0B, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1};
        vecs[4]  = '{"div_m7_2", 5'h0C, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32};
        vecs[5]  = '{"rem_m7_2", 5'h0E, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32};
        vecs[6]  = '{"divu_z",   5'h0D, 32'd100,      32'd0,        32'hFFFFFFFF, 1};
        vecs[7]  = '{"remu_z",   5'h0F, 32'd100,      32'd0,        32'd100,      1};
        vecs[8]  = '{"div_ovf",  5'h0C, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[9]  = '{"rem_ovf",  5'h0E, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[10] = '{"divu_10_3",5'h0D, 32'd10,       32'd3,        32'd3,        32};
        vecs[11] = '{"remu_max7",5'h0F, 32'hFFFFFFFF, 32'd7,        32'd3,        32};
        vecs[12] = '{"div_z",    5'h0C, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1};
        vecs[13] = '{"rem_z",    5'h0E, 32'h80000000, 32'd0,        32'h80000000, 1};
        vecs[14] = '{"div_20_m6",5'h0C, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 32};
        vecs[15] = '{"rem_20_m6",5'h0E, 32'd20,       32'hFFFFFFFA, 32'd2,        32};

        rst_n      = 1'b0;
        bus.START  = 1'b0;
        bus.FLUSH  = 1'b0;
        bus.SELECT = '0;
        bus.DATA1  = '0;
        bus.DATA2  = '0;
        #12;
        check("rst_result", bus.RESULT, 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_stall", 32'(bus.STALL), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].sel, vecs[i].d1, vecs[i].d2,
                   res, lat, busy_n, stall_n, dstall);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            check({vecs[i].name, "_busy"}, 32'(busy_n), 32'(vecs[i].lat + 1));
            check({vecs[i].name, "_stall"}, 32'(stall_n), 32'(vecs[i].lat + 1));
            check({vecs[i].name, "_done_stall"}, 32'(dstall), 32'd0);
            check({vecs[i].name, "_idle"}, 32'(bus.BUSY), 32'd0);
        end

        bus.START  = 1'b1;
        bus.SELECT = 5'b00000;
        #1;
        check("ign_stall", 32'(bus.STALL), 32'd0);
        @(posedge clk); #1;
        check("ign_busy", 32'(bus.BUSY), 32'd0);
        bus.START = 1'b0;

        bus.START  = 1'b1;
        bus.SELECT = 5'h08;
        bus.DATA1  = 32'd7;
        bus.DATA2  = 32'hFFFFFFFD;
        @(posedge clk); #1;
        bus.SELECT = 5'h0D;
        bus.DATA1  = 32'd10;
        bus.DATA2  = 32'd3;
        @(posedge clk); #1;
        check("b2b_done1", 32'(bus.DONE), 32'd1);
        check("b2b_res1", bus.RESULT, 32'hFFFFFFEB);
        check("b2b_stall_done", 32'(bus.STALL), 32'd1);
        @(posedge clk); #1;
        bus.START = 1'b0;
        check("b2b_no_idle", 32'(bus.BUSY), 32'd1);
        check("b2b_not_done", 32'(bus.DONE), 32'd0);
        lat = 0;
        while (!bus.DONE && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_lat2", 32'(lat), 32'd32);
        check("b2b_res2", bus.RESULT, 32'd3);
        @(posedge clk); #1;

        bus.START  = 1'b1;
        bus.SELECT = 5'h0C;
        bus.DATA1  = 32'd1000;
        bus.DATA2  = 32'd7;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("fl_busy_pre", 32'(bus.BUSY), 32'd1);
        bus.FLUSH = 1'b1;
        @(posedge clk); #1;
        bus.FLUSH = 1'b0;
        check("fl_busy", 32'(bus.BUSY), 32'd0);
        check("fl_done", 32'(bus.DONE), 32'd0);
        check("fl_res", bus.RESULT, 32'd3);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= bus.DONE;
        end
        check("fl_no_done", 32'(seen), 32'd0);

        bus.FLUSH  = 1'b1;
        bus.START  = 1'b1;
        bus.SELECT = 5'h08;
        @(posedge clk); #1;
        check("fl_cancel_start", 32'(bus.BUSY), 32'd0);
        bus.FLUSH = 1'b0;
        bus.START = 1'b0;

        bus.START  = 1'b1;
        bus.SELECT = 5'h0C;
        bus.DATA1  = 32'd1000;
        bus.DATA2  = 32'd7;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("rs_busy_pre", 32'(bus.BUSY), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_result", bus.RESULT, 32'd0);
        check("rs_busy", 32'(bus.BUSY), 32'd0);
        check("rs_done", 32'(bus.DONE), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
